iir_shift_filter: RTL



---
 rtl/iir_shift_filter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/iir_shift_filter.sv
// Multiplier-free recursive filter: each tap is en ? +/-(v >>> shift) : 0 with programmable
// coefficients, valid-qualified samples, saturate-or-wrap output and a flush that keeps coefficients.
module iir_shift_filter #(
  parameter int NB_DATA  = 8,
  parameter int N_FF     = 4,
  parameter int N_FB     = 2,
  parameter int NB_SHIFT = 3,
  parameter int NB_ADDR  = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  input  logic signed [NB_DATA-1:0]   i_data,
  input  logic                        i_flush,
  input  logic                        i_sat_en,
  input  logic                        i_cfg_we,
  input  logic        [NB_ADDR-1:0]   i_cfg_addr,
  input  logic        [NB_SHIFT+1:0]  i_cfg_data,
  output logic                        o_valid,
  output logic signed [NB_DATA-1:0]   o_data,
  output logic                        o_ovf
);

  localparam int N_TAP   = N_FF + N_FB;
  localparam int NB_COEF = NB_SHIFT + 2;
  localparam int NB_SUM  = NB_DATA + $clog2(N_TAP) + 1;

  localparam logic signed [NB_SUM-1:0]  SUM_MAX  = NB_SUM'((2 ** (NB_DATA - 1)) - 1);
  localparam logic signed [NB_SUM-1:0]  SUM_MIN  = NB_SUM'(-(2 ** (NB_DATA - 1)));
  localparam logic signed [NB_DATA-1:0] DATA_MAX = {1'b0, {(NB_DATA - 1){1'b1}}};
  localparam logic signed [NB_DATA-1:0] DATA_MIN = {1'b1, {(NB_DATA - 1){1'b0}}};

  // Coefficient layout is {en, neg, shift}; defaults give y = x0 - x1 + x2 + x3 + y1/2 + y2/4.
  function automatic logic [NB_COEF-1:0] defaultCoef(input int idx);
    logic [NB_COEF-1:0] c;
    c = '0;
    if (idx < N_FF) begin
      case (idx)
        0, 2, 3: c = {1'b1, 1'b0, NB_SHIFT'(0)};
        1:       c = {1'b1, 1'b1, NB_SHIFT'(0)};
        default: c = '0;
      endcase
    end else begin
      case (idx - N_FF)
        0:       c = {1'b1, 1'b0, NB_SHIFT'(1)};
        1:       c = {1'b1, 1'b0, NB_SHIFT'(2)};
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  logic        [NB_COEF-1:0]  r_coef [0:N_TAP-1];
  logic signed [NB_DATA-1:0]  r_x    [1:N_FF-1];
  logic signed [NB_DATA-1:0]  r_y    [1:N_FB];
  logic                       r_valid;
  logic                       r_ovf;

  logic signed [NB_DATA-1:0]  w_tapIn   [0:N_TAP-1];
  logic signed [NB_SUM-1:0]   w_ext     [0:N_TAP-1];
  logic signed [NB_SUM-1:0]   w_shifted [0:N_TAP-1];
  logic signed [NB_SUM-1:0]   w_term    [0:N_TAP-1];
  logic signed [NB_SUM-1:0]   w_sum;
  logic                       w_ovf;
  logic signed [NB_DATA-1:0]  w_result;

  // Full-precision sum: the accumulator is wide enough that no tap or partial sum can overflow.
  always_comb begin
    w_tapIn[0] = i_data;
    for (int k = 1; k < N_FF; k++) w_tapIn[k] = r_x[k];
    for (int j = 0; j < N_FB; j++) w_tapIn[N_FF + j] = r_y[j + 1];
    w_sum = '0;
    for (int t = 0; t < N_TAP; t++) begin
      w_ext[t]     = {{(NB_SUM - NB_DATA){w_tapIn[t][NB_DATA-1]}}, w_tapIn[t]};
      w_shifted[t] = w_ext[t] >>> r_coef[t][NB_SHIFT-1:0];
      if (!r_coef[t][NB_SHIFT+1])
        w_term[t] = '0;
      else if (r_coef[t][NB_SHIFT])
        w_term[t] = -w_shifted[t];
      else
        w_term[t] = w_shifted[t];
      w_sum = w_sum + w_term[t];
    end
  end

  assign w_ovf = (w_sum > SUM_MAX) || (w_sum < SUM_MIN);

  always_comb begin
    w_result = w_sum[NB_DATA-1:0];
    if (w_ovf && i_sat_en)
      w_result = w_sum[NB_SUM-1] ? DATA_MIN : DATA_MAX;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int t = 0; t < N_TAP; t++) r_coef[t] <= defaultCoef(t);
      for (int k = 1; k < N_FF; k++) r_x[k] <= '0;
      for (int j = 1; j <= N_FB; j++) r_y[j] <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      // Out-of-range addresses match no tap, so those writes fall away.
      for (int t = 0; t < N_TAP; t++)
        if (i_cfg_we && ({1'b0, i_cfg_addr} == (NB_ADDR + 1)'(t)))
          r_coef[t] <= i_cfg_data;
      if (i_flush) begin
        for (int k = 1; k < N_FF; k++) r_x[k] <= '0;
        for (int j = 1; j <= N_FB; j++) r_y[j] <= '0;
        r_valid <= 1'b0;
        r_ovf   <= 1'b0;
      end else if (i_valid) begin
        r_x[1] <= i_data;
        for (int k = 2; k < N_FF; k++) r_x[k] <= r_x[k-1];
        r_y[1] <= w_result;
        for (int j = 2; j <= N_FB; j++) r_y[j] <= r_y[j-1];
        r_valid <= 1'b1;
        r_ovf   <= w_ovf;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_y[1];
  assign o_valid = r_valid;
  assign o_ovf   = r_ovf;

endmodule
